// File: rtl/rr_pkg.sv
// Shared constants and FSM state type for the round-robin packet mux.
package rr_pkg;

  localparam int N_SRC_DEF  = 4;
  localparam int DATA_W_DEF = 32;

  // IDLE: arbitrating between sources; XFER: a source owns the output for one packet
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

endpackage

// File: rtl/pipe_reg.sv
// Single valid/ready register slice. It accepts a new word whenever it is
// empty or being drained in the same cycle, so it sustains full rate.
module pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  assign in_ready = ~out_valid | out_ready;

  // Load on accept, otherwise drop valid once the consumer takes the word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rr_packet_mux.sv
// Packet-locking mux behind an external round-robin arbiter. Requests go out
// only while idle, so the arbiter's rotation advances once per packet; the
// granted source then owns the output until its last beat is accepted.
module rr_packet_mux
  import rr_pkg::*;
#(
  parameter int N_SRC  = N_SRC_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int SRC_W  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_SRC-1:0]        s_valid,
  output logic [N_SRC-1:0]        s_ready,
  input  logic [N_SRC*DATA_W-1:0] s_data,
  input  logic [N_SRC-1:0]        s_last,
  output logic [N_SRC-1:0]        req_o,
  input  logic [N_SRC-1:0]        gnt_i,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [DATA_W-1:0]       m_data,
  output logic                    m_last,
  output logic [SRC_W-1:0]        m_src,
  output logic                    busy_o
);

  localparam int PW = SRC_W + 1 + DATA_W;

  state_t            state, state_nxt;
  logic [SRC_W-1:0]  owner, owner_nxt;
  logic [N_SRC-1:0]  hit;
  logic [SRC_W-1:0]  hit_idx;
  logic              sel_valid, sel_last;
  logic [DATA_W-1:0] sel_data;
  logic              fwd_valid, pipe_ready, accept;
  logic [PW-1:0]     pipe_in, pipe_out;

  // Requests are exposed only while idle; a grant for a non-requester is ignored
  assign req_o  = (state == ST_IDLE) ? s_valid : '0;
  assign hit    = gnt_i & req_o;
  assign busy_o = (state == ST_XFER);

  // One-hot (or stray multi-hot) grant to index, lowest set bit wins
  always_comb begin
    hit_idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (hit[i]) hit_idx = SRC_W'(i);
    end
  end

  // Select the owning source's beat
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (owner == SRC_W'(i)) begin
        sel_valid = s_valid[i];
        sel_last  = s_last[i];
        sel_data  = s_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Only the owner sees ready, and only when the output slice can take a beat
  always_comb begin
    s_ready = '0;
    if (state == ST_XFER) begin
      for (int i = 0; i < N_SRC; i++) begin
        if (owner == SRC_W'(i)) s_ready[i] = pipe_ready;
      end
    end
  end

  assign fwd_valid = (state == ST_XFER) & sel_valid;
  assign accept    = fwd_valid & pipe_ready;

  // Next state: lock on grant, release once the last beat is accepted
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    case (state)
      ST_IDLE: begin
        if (|hit) begin
          owner_nxt = hit_idx;
          state_nxt = ST_XFER;
        end
      end
      ST_XFER: begin
        if (accept && sel_last) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State and owner registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      owner <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
    end
  end

  assign pipe_in = {owner, sel_last, sel_data};

  pipe_reg #(.W(PW)) u_out (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (fwd_valid),
    .in_ready  (pipe_ready),
    .in_data   (pipe_in),
    .out_valid (m_valid),
    .out_ready (m_ready),
    .out_data  (pipe_out)
  );

  assign m_src  = pipe_out[PW-1 -: SRC_W];
  assign m_last = pipe_out[DATA_W];
  assign m_data = pipe_out[DATA_W-1:0];

endmodule

// File: tb/tb_rr_packet_mux.sv
// Bench for rr_packet_mux with a behavioural round-robin arbiter attached.
module tb_rr_packet_mux;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    s_valid, s_ready, s_last, req_o, gnt_i;
  logic [N*DW-1:0] s_data;
  logic            m_valid, m_ready, m_last, busy_o;
  logic [DW-1:0]   m_data;
  logic [SW-1:0]   m_src;

  rr_packet_mux #(.N_SRC(N), .DATA_W(DW), .SRC_W(SW)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .req_o(req_o), .gnt_i(gnt_i), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .m_src(m_src), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Round-robin arbiter: search starts at ptr, ptr moves past each winner
  int   ptr;
  logic arb_found;
  always_comb begin
    gnt_i     = '0;
    arb_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!arb_found && req_o[(ptr + k) % N]) begin
        gnt_i[(ptr + k) % N] = 1'b1;
        arb_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr <= 0;
    else for (int k = 0; k < N; k++) if (gnt_i[k]) ptr <= (k + 1) % N;
  end

  typedef struct packed {
    logic [31:0] cyc;
    logic [1:0]  src;
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t       sb[$];
  beat_t       acc_log[$];
  beat_t       out_log[$];
  logic [32:0] src_q [N][$];

  int   checks = 0, passes = 0;
  int   cyc = 0, mr_lo = -1, mr_hi = -1;
  int   stall_cnt = 0, busy_cnt = 0;
  logic prev_stall = 1'b0;
  logic [34:0] prev_out;

  task automatic drive_inputs();
    logic [32:0] h;
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) begin
        h = src_q[i][0];
        s_valid[i] = 1'b1;
        s_data[i*DW +: DW] = h[31:0];
        s_last[i] = h[32];
      end else begin
        s_valid[i] = 1'b0;
        s_data[i*DW +: DW] = '0;
        s_last[i] = 1'b0;
      end
    end
    m_ready = !(cyc >= mr_lo && cyc <= mr_hi);
  endtask

  function automatic bit srcs_pending();
    for (int i = 0; i < N; i++) if (src_q[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: sample mid-cycle, score outputs, log accepts, advance sources
  task automatic step();
    logic [N-1:0] acc;
    logic [32:0]  h;
    beat_t        b, e;
    #1;
    acc = s_valid & s_ready;
    checks++;
    if (busy_o ? (req_o !== 4'b0) : (req_o !== s_valid || s_ready !== 4'b0)) begin
      $display("FAIL req_ready cyc=%0d busy=%b req_o=%b s_valid=%b s_ready=%b", cyc, busy_o, req_o, s_valid, s_ready);
    end else passes++;
    checks++;
    if ($countones(s_ready) > 1 || (m_valid && !m_ready && s_ready !== 4'b0)) begin
      $display("FAIL ready_excl cyc=%0d s_ready=%b m_valid=%b m_ready=%b", cyc, s_ready, m_valid, m_ready);
    end else passes++;
    if (prev_stall) begin
      checks++;
      if (m_valid !== 1'b1 || {m_src, m_last, m_data} !== prev_out) begin
        $display("FAIL hold cyc=%0d got v=%b %h want v=1 %h", cyc, m_valid, {m_src, m_last, m_data}, prev_out);
      end else passes++;
    end
    if (m_valid && !m_ready) stall_cnt++;
    if (busy_o) busy_cnt++;
    if (m_valid && m_ready) begin
      b.cyc = 32'(cyc); b.src = m_src; b.data = m_data; b.last = m_last;
      out_log.push_back(b);
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL scoreboard cyc=%0d unexpected beat src=%0d data=%h last=%b", cyc, m_src, m_data, m_last);
      end else begin
        e = sb.pop_front();
        if ({m_src, m_data, m_last} !== {e.src, e.data, e.last})
          $display("FAIL scoreboard cyc=%0d got src=%0d data=%h last=%b want src=%0d data=%h last=%b",
                   cyc, m_src, m_data, m_last, e.src, e.data, e.last);
        else passes++;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        h = src_q[i][0];
        b.cyc = 32'(cyc); b.src = 2'(i); b.data = h[31:0]; b.last = h[32];
        sb.push_back(b);
        acc_log.push_back(b);
      end
    end
    prev_stall = m_valid && !m_ready;
    prev_out   = {m_src, m_last, m_data};
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) if (acc[i]) void'(src_q[i].pop_front());
    cyc++;
    drive_inputs();
  endtask

  task automatic drain(input int bound, output bit tout);
    int n = 0;
    while ((sb.size() > 0 || m_valid || busy_o || srcs_pending()) && n < bound) begin
      step();
      n++;
    end
    tout = (n >= bound);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    for (int i = 0; i < N; i++) src_q[i].delete();
    sb.delete();
    acc_log.delete();
    out_log.delete();
    mr_lo = -1; mr_hi = -1;
    drive_inputs();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    prev_stall = 1'b0;
    stall_cnt = 0;
    busy_cnt = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    src_q[1].push_back({1'b0, 32'h0000_0011});
    src_q[3].push_back({1'b1, 32'h0000_0033});
    drive_inputs();
    @(posedge clk); #1;
    checks++;
    if (s_ready !== 4'b0 || busy_o !== 1'b0)
      $display("FAIL reset_ready got s_ready=%b busy=%b want 0000 0", s_ready, busy_o);
    else passes++;
    checks++;
    if (m_valid !== 1'b0 || m_data !== 32'h0 || m_last !== 1'b0 || m_src !== 2'd0)
      $display("FAIL reset_out got v=%b d=%h l=%b s=%0d want all 0", m_valid, m_data, m_last, m_src);
    else passes++;
    reset = 1'b0;
    #1;
    checks++;
    if (req_o !== 4'b1010 || m_valid !== 1'b0 || busy_o !== 1'b0)
      $display("FAIL reset_release got req_o=%b v=%b busy=%b want 1010 0 0", req_o, m_valid, busy_o);
    else passes++;
  endtask

  task automatic test_three_beat();
    bit tout;
    logic [31:0] exp_d [3];
    exp_d = '{32'hA000_0001, 32'hB000_0002, 32'hC000_0003};
    apply_reset();
    for (int j = 0; j < 3; j++) src_q[1].push_back({(j == 2), exp_d[j]});
    drive_inputs();
    drain(50, tout);
    checks++;
    if (tout || out_log.size() != 3)
      $display("FAIL three_count got %0d beats timeout=%0d want 3", out_log.size(), tout);
    else passes++;
    if (out_log.size() == 3 && acc_log.size() == 3) begin
      for (int j = 0; j < 3; j++) begin
        checks++;
        if (out_log[j].data !== exp_d[j] || out_log[j].src !== 2'd1 || out_log[j].last !== (j == 2))
          $display("FAIL three_beat%0d got d=%h s=%0d l=%b want d=%h s=1 l=%b", j,
                   out_log[j].data, out_log[j].src, out_log[j].last, exp_d[j], (j == 2));
        else passes++;
      end
      checks++;
      if (out_log[2].cyc - out_log[0].cyc != 2 || out_log[0].cyc - acc_log[0].cyc != 1)
        $display("FAIL three_timing got span=%0d lat=%0d want 2 1",
                 out_log[2].cyc - out_log[0].cyc, out_log[0].cyc - acc_log[0].cyc);
      else passes++;
    end
  endtask

  task automatic test_rr_all();
    bit tout;
    int pk;
    apply_reset();
    for (int p = 0; p < 3; p++)
      for (int s = 0; s < N; s++)
        for (int b = 0; b < 2; b++)
          src_q[s].push_back({(b == 1), 8'hC0, 8'(s), 8'(p), 8'(b)});
    drive_inputs();
    drain(200, tout);
    checks++;
    if (tout || out_log.size() != 24)
      $display("FAIL rr_count got %0d beats timeout=%0d want 24", out_log.size(), tout);
    else passes++;
    pk = 0;
    for (int j = 0; j < out_log.size(); j++) begin
      if (out_log[j].last) begin
        checks++;
        if (out_log[j].src !== 2'(pk % N))
          $display("FAIL rr_order pkt%0d got src=%0d want %0d", pk, out_log[j].src, pk % N);
        else passes++;
        pk++;
      end
    end
    for (int j = 1; j < acc_log.size(); j++) begin
      checks++;
      if (acc_log[j].cyc - acc_log[j-1].cyc != (acc_log[j-1].last ? 2 : 1) ||
          (!acc_log[j-1].last && acc_log[j].src !== acc_log[j-1].src))
        $display("FAIL rr_gap beat%0d got gap=%0d src=%0d prev_src=%0d want gap=%0d", j,
                 acc_log[j].cyc - acc_log[j-1].cyc, acc_log[j].src, acc_log[j-1].src,
                 acc_log[j-1].last ? 2 : 1);
      else passes++;
    end
  endtask

  task automatic test_backpressure();
    bit tout;
    apply_reset();
    mr_lo = cyc + 4;
    mr_hi = cyc + 7;
    for (int b = 0; b < 4; b++) src_q[2].push_back({(b == 3), 32'h2200_0000 + 32'(b)});
    drive_inputs();
    drain(60, tout);
    checks++;
    if (tout || out_log.size() != 4 || stall_cnt != 4)
      $display("FAIL bp_count got beats=%0d stalls=%0d timeout=%0d want 4 4 0", out_log.size(), stall_cnt, tout);
    else passes++;
    for (int j = 0; j < out_log.size() && j < 4; j++) begin
      checks++;
      if (out_log[j].data !== 32'h2200_0000 + 32'(j) || out_log[j].src !== 2'd2)
        $display("FAIL bp_beat%0d got d=%h s=%0d want d=%h s=2", j, out_log[j].data, out_log[j].src,
                 32'h2200_0000 + 32'(j));
      else passes++;
    end
  endtask

  task automatic test_single_beat();
    bit tout;
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      src_q[0].push_back({1'b1, 32'hD000_0000 + 32'(k)});
      src_q[3].push_back({1'b1, 32'hD300_0000 + 32'(k)});
    end
    drive_inputs();
    drain(100, tout);
    checks++;
    if (tout || out_log.size() != 8 || busy_cnt != 8)
      $display("FAIL single_count got beats=%0d busy_cycles=%0d timeout=%0d want 8 8 0", out_log.size(), busy_cnt, tout);
    else passes++;
    for (int j = 0; j < out_log.size() && j < 8; j++) begin
      checks++;
      if (out_log[j].src !== ((j % 2 == 0) ? 2'd0 : 2'd3) || out_log[j].last !== 1'b1)
        $display("FAIL single_order%0d got s=%0d l=%b want s=%0d l=1", j, out_log[j].src, out_log[j].last,
                 (j % 2 == 0) ? 0 : 3);
      else passes++;
    end
  endtask

  task automatic test_reset_mid();
    bit tout;
    int n = 0;
    apply_reset();
    for (int b = 0; b < 4; b++) src_q[1].push_back({(b == 3), 32'hE100_0000 + 32'(b)});
    drive_inputs();
    while (acc_log.size() < 2 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (acc_log.size() < 2 || out_log.size() != 1 || out_log[0].last !== 1'b0)
      $display("FAIL mid_pre got accepts=%0d outs=%0d want 2 1", acc_log.size(), out_log.size());
    else passes++;
    reset = 1'b1;
    #1;
    checks++;
    if (m_valid !== 1'b0 || m_last !== 1'b0 || busy_o !== 1'b0 || s_ready !== 4'b0)
      $display("FAIL mid_reset got v=%b l=%b busy=%b s_ready=%b want 0 0 0 0000", m_valid, m_last, busy_o, s_ready);
    else passes++;
    for (int i = 0; i < N; i++) src_q[i].delete();
    sb.delete(); acc_log.delete(); out_log.delete();
    drive_inputs();
    @(posedge clk); #1;
    reset = 1'b0;
    prev_stall = 1'b0;
    for (int b = 0; b < 4; b++) src_q[1].push_back({(b == 3), 32'hF100_0000 + 32'(b)});
    drive_inputs();
    drain(50, tout);
    checks++;
    if (tout || out_log.size() != 4)
      $display("FAIL mid_restart got %0d beats timeout=%0d want 4", out_log.size(), tout);
    else passes++;
    for (int j = 0; j < out_log.size() && j < 4; j++) begin
      checks++;
      if (out_log[j].data !== 32'hF100_0000 + 32'(j) || out_log[j].src !== 2'd1 || out_log[j].last !== (j == 3))
        $display("FAIL mid_beat%0d got d=%h s=%0d l=%b want d=%h s=1 l=%b", j, out_log[j].data,
                 out_log[j].src, out_log[j].last, 32'hF100_0000 + 32'(j), (j == 3));
      else passes++;
    end
  endtask

  initial begin
    s_valid = '0; s_data = '0; s_last = '0; m_ready = 1'b1;
    test_reset();
    test_three_beat();
    test_rr_all();
    test_backpressure();
    test_single_beat();
    test_reset_mid();
    checks++;
    if (sb.size() != 0)
      $display("FAIL sb_empty got %0d leftover beats want 0", sb.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule
